ym3438_timers: RTL

Timer A / Timer B unit of the ym3438 core. It counts sample ticks from the FSM, raises the overflow flags and IRQ, and drives the `timer_a`/`timer_b` status inputs of `ym3438_io`. Its load, enable and reset controls come from `ym3438_reg_ctrl`, decoded from registers 0x24–0x27. It also emits a per-overflow pulse of Timer A for the CSM key-on logic downstream.

---
 rtl/ym3438_pkg.sv | 16 +
 rtl/ym3438_timer_cnt.sv | 37 +++
 rtl/ym3438_timers.sv | 45 ++++
 3 files changed

// File: rtl/ym3438_pkg.sv
// ym3438_pkg: shared widths, timer register addresses and 0x27 control bit positions
package ym3438_pkg;
    localparam int TA_W = 10;
    localparam int TB_W = 8;
    localparam int TB_PRE_W = 4;
    localparam logic [7:0] REG_TA_HI = 8'h24;
    localparam logic [7:0] REG_TA_LO = 8'h25;
    localparam logic [7:0] REG_TB = 8'h26;
    localparam logic [7:0] REG_TCTRL = 8'h27;
    localparam int BIT_LOAD_A = 0;
    localparam int BIT_LOAD_B = 1;
    localparam int BIT_EN_A = 2;
    localparam int BIT_EN_B = 3;
    localparam int BIT_RST_A = 4;
    localparam int BIT_RST_B = 5;
endpackage

// File: rtl/ym3438_timer_cnt.sv
// ym3438_timer_cnt: up-counter with load-edge reload, overflow pulse and sticky flag
module ym3438_timer_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tick,
    input  logic         step,
    input  logic         load,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] value,
    output logic         flag,
    output logic         ovf
);
    logic [W-1:0] cnt;
    logic load_d, load_edge, ovf_now;
    always_comb begin
        load_edge = tick & load & ~load_d;
        ovf_now = step & load & ~load_edge & (cnt == '1);
    end
    // a set on the same cycle as clr wins so no overflow is lost
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            load_d <= 1'b0;
            flag <= 1'b0;
            ovf <= 1'b0;
        end else begin
            if (tick) load_d <= load;
            if (load_edge | ovf_now) cnt <= value;
            else if (step & load) cnt <= cnt + W'(1);
            flag <= (ovf_now & en) | (flag & ~clr);
            ovf <= ovf_now;
        end
    end
endmodule

// File: rtl/ym3438_timers.sv
// ym3438_timers: Timer A/B with free-running /16 Timer B prescaler and combined IRQ
module ym3438_timers
    import ym3438_pkg::*;
#(
    parameter int TA_W = ym3438_pkg::TA_W,
    parameter int TB_W = ym3438_pkg::TB_W,
    parameter int TB_PRE_W = ym3438_pkg::TB_PRE_W
) (
    input  logic            MCLK,
    input  logic            IC,
    input  logic            c1,
    input  logic            timer_ed,
    input  logic [TA_W-1:0] ta_value,
    input  logic [TB_W-1:0] tb_value,
    input  logic            load_a,
    input  logic            load_b,
    input  logic            en_a,
    input  logic            en_b,
    input  logic            rst_a,
    input  logic            rst_b,
    output logic            timer_a,
    output logic            timer_b,
    output logic            irq,
    output logic            ta_ovf
);
    logic tick, step_b, unused_tb_ovf;
    logic [TB_PRE_W-1:0] pre;
    always_comb begin
        tick = timer_ed & c1;
        step_b = tick & (pre == '1);
        irq = timer_a | timer_b;
    end
    always_ff @(posedge MCLK) begin
        if (IC) pre <= '0;
        else if (tick) pre <= pre + TB_PRE_W'(1);
    end
    ym3438_timer_cnt #(.W(TA_W)) u_ta (
        .clk(MCLK), .rst(IC), .tick(tick), .step(tick), .load(load_a), .en(en_a),
        .clr(rst_a), .value(ta_value), .flag(timer_a), .ovf(ta_ovf)
    );
    ym3438_timer_cnt #(.W(TB_W)) u_tb (
        .clk(MCLK), .rst(IC), .tick(tick), .step(step_b), .load(load_b), .en(en_b),
        .clr(rst_b), .value(tb_value), .flag(timer_b), .ovf(unused_tb_ovf)
    );
endmodule
